vending_change_dispenser: RTL and testbench
===========================================

# vending_change_dispenser

Payout controller on the output side of the vending machine. It captures the `balance` value when the machine signals `dispense`, then pays that amount back one coin at a time to a coin hopper through a valid/ack handshake. Coins are chosen greedily from the denominations 5, 2 and 1. An ack timeout and an overrun indicator flag hopper faults and lost requests.

## Interface
- `ACK_TIMEOUT`, default 8: number of cycles a coin may be presented without ack before the block enters ERROR (legal range 1..255).
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `dispense` input 1: vending machine has completed a sale; `balance` is valid in the same cycle.
- `balance` input 4: change owed, in units, range 0..15.
- `coin_ack` input 1: hopper has accepted the presented coin.
- `clear` input 1: leaves ERROR and returns to IDLE.
- `coin_valid` output 1: a coin is being presented to the hopper.
- `coin_value` output 3: value of the presented coin (1, 2 or 5); 0 when `coin_valid` is 0.
- `remaining` output 4: change still owed.
- `busy` output 1: high in PAY.
- `done` output 1: one-cycle pulse when payout is complete.
- `error` output 1: high in ERROR.
- `overrun` output 1: one-cycle pulse when a `dispense` request is dropped.

## Operation
- **States:** IDLE, PAY, DONE, ERROR. All outputs are registered or decoded directly from state/registers.
- **Reset:** state IDLE; `remaining`=0, wait counter=0; `coin_valid`, `coin_value`, `busy`, `done`, `error`, `overrun` all 0. Reset overrides everything, including mid-PAY; the partial payout is abandoned with no `done`.
- **IDLE:**
  - `dispense`=1 with `balance`≠0 → `remaining`←`balance`, wait counter←0, go to PAY.
  - `dispense`=1 with `balance`=0 → go to DONE.
  - `coin_ack` and `clear` are ignored.
- **PAY:**
  - `coin_valid`=1. `coin_value` is 5 if `remaining`≥5, else 2 if `remaining`≥2, else 1.
  - `coin_ack`=1 → `remaining`←`remaining`−`coin_value` and wait counter←0. If the result is 0, go to DONE; otherwise stay in PAY and present the next coin in the next cycle (`coin_valid` stays high).
  - `coin_ack`=0 → if wait counter = `ACK_TIMEOUT`−1, go to ERROR; otherwise increment the wait counter.
- **DONE:** lasts exactly one cycle with `done`=1, `coin_valid`=0, then returns to IDLE.
- **ERROR:**
  - `error`=1, `coin_valid`=0, `remaining` holds the unpaid amount.
  - `clear`=1 → go to IDLE and set `remaining`←0.
  - `coin_ack` is ignored.
- **Overrun:** `dispense`=1 in PAY, DONE or ERROR is dropped and sets `overrun`=1 for the following cycle. State is unaffected.
- **Arithmetic:** the subtraction never underflows because the greedy choice never exceeds `remaining`. Worst-case payout is 4 coins (e.g. 13 = 5+5+2+1, 14 = 5+5+2+2).

## Timing
- **Request to first coin:** `dispense` sampled at edge E → `coin_valid`=1 in the cycle after E.
- **Throughput:** with `coin_ack` held high, one coin per cycle.
- **Completion:** `done` asserts the cycle after the edge that accepts the last coin, or the cycle after the request edge when `balance`=0.
- **Handshake:** the transfer completes at a rising edge where `coin_valid`=1 and `coin_ack`=1. `coin_value` is stable while `coin_valid` is high and no ack has occurred.
- **Timeout:** `coin_valid` stays high for exactly `ACK_TIMEOUT` consecutive un-acked cycles; `error` rises on the next cycle.
- **Back-to-back requests:** a new `dispense` is accepted no earlier than the cycle after `done` (i.e. back in IDLE).

## Test plan
- **Normal payout:** reset, then `dispense`=1 with `balance`=13, `coin_ack` held at 1 → `coin_value` sequence 5, 5, 2, 1 on 4 consecutive cycles; `remaining` goes 13 → 8 → 3 → 1 → 0; `done` pulses once the following cycle.
- **Zero balance:** `dispense`=1 with `balance`=0 → no `coin_valid`; `done`=1 the next cycle; `busy` stays 0.
- **Slow hopper:** `balance`=7, `coin_ack` asserted every third cycle → coins 5 then 2; `coin_value` holds steady between acks; single `done`; no `error`.
- **Timeout:** `ACK_TIMEOUT`=4, `balance`=6, first coin acked, then `coin_ack`=0 → coin 1 (value 5) accepted; `coin_valid`=1 with `coin_value`=1 for 4 cycles; `error`=1 with `remaining`=1. Then `clear` → IDLE with `remaining`=0.
- **Overrun:** `dispense` pulse with `balance`=9 during PAY of a `balance`=15 payout → `overrun` one-cycle pulse; coins 5, 5, 5 still paid; no second payout.
- **Reset mid-operation:** `reset` asserted during PAY with `remaining`=8 → next cycle all outputs 0 and state IDLE; a subsequent `balance`=3 request pays 2, 1.

Source files
------------

// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser
// Pays out a captured change balance one coin at a time to a coin hopper.
// Coins are chosen greedily from 5, 2 and 1. If a presented coin waits
// ACK_TIMEOUT cycles without an ack, the block parks in ERROR until clear.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   dispense, balance sale complete strobe with the change owed (0..15)
//   coin_ack          hopper accepted the presented coin
//   clear             leave ERROR and return to IDLE
//   coin_valid        a coin is being presented (PAY)
//   coin_value        value of the presented coin (1, 2, 5), 0 when idle
//   remaining         change still owed
//   busy              high in PAY
//   done              one-cycle pulse when payout completes
//   error             high in ERROR
//   overrun           one-cycle pulse after a dropped dispense request
module vending_change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dispense,
  input  logic [3:0] balance,
  input  logic       coin_ack,
  input  logic       clear,
  output logic       coin_valid,
  output logic [2:0] coin_value,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAY   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] rem_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       overrun_nxt;
  logic [2:0] coin_sel;
  logic [3:0] rem_after;

  // Greedy denomination for the current remainder; it never exceeds
  // remaining (for remaining >= 1), so the subtraction cannot underflow.
  always_comb begin
    if (remaining >= 4'd5)      coin_sel = 3'd5;
    else if (remaining >= 4'd2) coin_sel = 3'd2;
    else                        coin_sel = 3'd1;
  end

  assign rem_after = remaining - {1'b0, coin_sel};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      wait_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      wait_cnt  <= wait_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rem_nxt     = remaining;
    wait_nxt    = wait_cnt;
    overrun_nxt = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (dispense) begin
          if (balance != 4'd0) begin
            rem_nxt   = balance;
            wait_nxt  = '0;
            state_nxt = S_PAY;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end

      S_PAY: begin
        overrun_nxt = dispense;
        if (coin_ack) begin
          rem_nxt  = rem_after;
          wait_nxt = '0;
          if (rem_after == 4'd0) state_nxt = S_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_ERROR;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end

      S_DONE: begin
        overrun_nxt = dispense;
        state_nxt   = S_IDLE;
      end

      S_ERROR: begin
        overrun_nxt = dispense;
        if (clear) begin
          rem_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded straight from the state/remaining
  // registers, so coin_value holds steady until an ack changes remaining.
  assign coin_valid = (state == S_PAY);
  assign coin_value = coin_valid ? coin_sel : 3'd0;
  assign busy       = (state == S_PAY);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);

endmodule

// File: tb/tb_vending_change_dispenser.sv
module tb_vending_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, dispense, coin_ack, clear;
  logic [3:0] balance;
  logic       coin_valid, busy, done, error, overrun;
  logic [2:0] coin_value;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_change_dispenser #(.ACK_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .dispense   (dispense),
    .balance    (balance),
    .coin_ack   (coin_ack),
    .clear      (clear),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .overrun    (overrun)
  );

  // Inputs driven before an edge; expected outputs observed after it.
  // Expected vector packing: {coin_valid, coin_value[2:0], remaining[3:0], busy, done, error, overrun}
  typedef struct {
    logic        rst;
    logic        disp;
    logic [3:0]  bal;
    logic        ack;
    logic        clr;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [10:0] o(input logic cv, input logic [2:0] val,
                                    input logic [3:0] rem, input logic bsy,
                                    input logic dn, input logic er,
                                    input logic ov);
    return {cv, val, rem, bsy, dn, er, ov};
  endfunction

  task automatic add(input logic rst, input logic disp, input logic [3:0] bal,
                     input logic ack, input logic clr, input logic [10:0] exp);
    vec_t v;
    v.rst = rst; v.disp = disp; v.bal = bal; v.ack = ack; v.clr = clr; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [10:0] actual();
    return {coin_valid, coin_value, remaining, busy, done, error, overrun};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b (cv,val,rem,busy,done,err,ovr)", name, got, want);
    end
  endtask

  function automatic logic [2:0] greedy(input logic [3:0] r);
    if (r >= 4'd5) return 3'd5;
    if (r >= 4'd2) return 3'd2;
    return 3'd1;
  endfunction

  initial begin
    logic [3:0] mrem;
    int         ndone;
    logic       finished;

    reset = 1'b1; dispense = 1'b0; balance = '0; coin_ack = 1'b0; clear = 1'b0;

    //     rst disp bal   ack clr   cv val   rem    busy done err ovr
    // reset state
    add(1, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // normal payout 13 = 5+5+2+1 with ack held
    add(0, 1, 4'd13, 1, 0, o(1, 3'd5, 4'd13, 1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(1, 3'd5, 4'd8,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(1, 3'd2, 4'd3,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(0, 3'd0, 4'd0,  0, 1, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // zero balance goes straight to DONE
    add(0, 1, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 1, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // overrun during a 15 payout
    add(0, 1, 4'd15, 0, 0, o(1, 3'd5, 4'd15, 1, 0, 0, 0));
    add(0, 1, 4'd9,  1, 0, o(1, 3'd5, 4'd10, 1, 0, 0, 1));
    add(0, 0, 4'd0,  1, 0, o(1, 3'd5, 4'd5,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(0, 3'd0, 4'd0,  0, 1, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // reset mid-PAY, then 3 = 2+1
    add(0, 1, 4'd8,  0, 0, o(1, 3'd5, 4'd8,  1, 0, 0, 0));
    add(1, 0, 4'd0,  1, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    add(0, 1, 4'd3,  1, 0, o(1, 3'd2, 4'd3,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(0, 3'd0, 4'd0,  0, 1, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // timeout (ACK_TIMEOUT=4): 6 -> first coin acked, then 4 un-acked cycles
    add(0, 1, 4'd6,  0, 0, o(1, 3'd5, 4'd6,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd1,  0, 0, 1, 0));
    // ERROR ignores ack, drops dispense, leaves on clear
    add(0, 1, 4'd4,  1, 0, o(0, 3'd0, 4'd1,  0, 0, 1, 1));
    add(0, 0, 4'd0,  0, 1, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // clear/ack ignored in IDLE; dispense during DONE dropped
    add(0, 0, 4'd0,  1, 1, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    add(0, 1, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 1, 0, 0));
    add(0, 1, 4'd5,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 1));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));
    // single-coin boundary: balance 1
    add(0, 1, 4'd1,  0, 0, o(1, 3'd1, 4'd1,  1, 0, 0, 0));
    add(0, 0, 4'd0,  1, 0, o(0, 3'd0, 4'd0,  0, 1, 0, 0));
    add(0, 0, 4'd0,  0, 0, o(0, 3'd0, 4'd0,  0, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; dispense = vecs[i].disp; balance = vecs[i].bal;
      coin_ack = vecs[i].ack; clear = vecs[i].clr;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
      @(negedge clk);
    end

    // Slow hopper: balance 7, ack on every third cycle.
    reset = 1'b0; clear = 1'b0; coin_ack = 1'b0;
    dispense = 1'b1; balance = 4'd7;
    @(posedge clk); #1;
    mrem = 4'd7;
    check("slow_start", actual(), o(1, greedy(mrem), mrem, 1, 0, 0, 0));
    @(negedge clk);
    dispense = 1'b0; balance = '0;
    ndone = 0; finished = 1'b0;
    for (int c = 0; c < 20 && !finished; c++) begin
      coin_ack = (c % 3 == 2);
      @(posedge clk); #1;
      if (coin_ack) mrem = mrem - {1'b0, greedy(mrem)};
      if (mrem == 4'd0) begin
        check($sformatf("slow_done%0d", c), actual(), o(0, 3'd0, 4'd0, 0, 1, 0, 0));
        ndone++;
        finished = 1'b1;
      end else begin
        check($sformatf("slow_pay%0d", c), actual(), o(1, greedy(mrem), mrem, 1, 0, 0, 0));
      end
      @(negedge clk);
    end
    coin_ack = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL slow_timeout got=no_done want=done");
    end
    // done must not repeat and error must stay low afterwards
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("slow_after%0d", c), actual(), o(0, 3'd0, 4'd0, 0, 0, 0, 0));
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL slow_done_count got=%0d want=1", ndone);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
